// File: rtl/mips_state_dumper.sv
// -----------------------------------------------------------------------------
// mips_state_dumper
//
// Walks a set of storage channels (register file, data memory, instruction
// memory, ...) and streams every word of each selected channel out over a
// valid/ready interface, while holding the processor frozen via cpu_stall.
//
// A dump request (start) is accepted only while idle. The channel mask is
// captured at that moment; each channel's last address is captured when the
// dumper enters that channel. Channels are visited in ascending index order,
// addresses 0..last within a channel. One word leaves every two cycles when
// the consumer never backpressures.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset, clears every register
//   start      dump request, honoured only in IDLE
//   ch_mask    channels to dump (bit i = channel i)
//   ch_last    last address per channel (slice i = channel i)
//   rd_ch      channel currently addressed
//   rd_addr    read address presented to all channels
//   rd_data    combinational read data of every channel at rd_addr
//   out_valid  dump word available
//   out_ready  consumer accepts the word
//   out_data   dumped word
//   out_addr   address of out_data
//   out_ch     channel of out_data
//   out_last   final word of the whole dump
//   cpu_stall  freezes the processor while a dump is in progress
//   busy       dumper is not idle
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module mips_state_dumper #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 10,
  parameter  int NUM_CH = 3,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_last,
  output logic [CH_W-1:0]            rd_ch,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_last,
  output logic                       cpu_stall,
  output logic                       busy,
  output logic                       done
);

  // The channel pointer must be able to hold NUM_CH itself (one past the
  // highest channel) after the last channel completes.
  localparam int PTR_W = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Lowest-index channel >= ptr whose mask bit is set.
  // Returns {found, index}.
  function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] mask,
                                               input logic [PTR_W-1:0]  ptr);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest qualifying index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
    return {found, idx};
  endfunction

  // True when any mask bit above channel ch is still set.
  function automatic logic higher_pending(input logic [NUM_CH-1:0] mask,
                                          input logic [CH_W-1:0]   ch);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      r = r | (mask[i] & (i > int'(ch)));
    end
    return r;
  endfunction

  state_t              state_q,     state_d;
  logic [NUM_CH-1:0]   mask_q,      mask_d;
  logic [PTR_W-1:0]    ptr_q,       ptr_d;
  logic [ADDR_W-1:0]   last_q,      last_d;
  logic [CH_W-1:0]     rd_ch_q,     rd_ch_d;
  logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [CH_W-1:0]     out_ch_q,    out_ch_d;
  logic                out_last_q,  out_last_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic [CH_W:0]       sel_s;
  logic                sel_found_s;
  logic [CH_W-1:0]     sel_idx_s;
  logic                at_last_s;
  logic                higher_s;

  // Channel selection and end-of-channel / end-of-dump detection.
  always_comb begin
    sel_s       = find_next(mask_q, ptr_q);
    sel_found_s = sel_s[CH_W];
    sel_idx_s   = sel_s[CH_W-1:0];
    at_last_s   = (rd_addr_q == last_q);
    higher_s    = higher_pending(mask_q, rd_ch_q);
  end

  // Next-state and next-output logic of the dump sequencer.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    rd_ch_d     = rd_ch_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = ch_mask;
          ptr_d   = '0;
          state_d = S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEL: begin
        if (sel_found_s) begin
          // ch_last is sampled only here, so slices of channels not yet
          // entered may still change while the dump runs.
          last_d    = ch_last[int'(sel_idx_s)*ADDR_W +: ADDR_W];
          rd_ch_d   = sel_idx_s;
          rd_addr_d = '0;
          state_d   = S_LOAD;
        end else begin
          state_d   = S_FIN;
        end
      end

      S_LOAD: begin
        out_data_d  = rd_data[int'(rd_ch_q)*DATA_W +: DATA_W];
        out_addr_d  = rd_addr_q;
        out_ch_d    = rd_ch_q;
        out_valid_d = 1'b1;
        out_last_d  = at_last_s & ~higher_s;
        state_d     = S_SEND;
      end

      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (!at_last_s) begin
            rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d   = S_LOAD;
          end else begin
            // Channel finished: retire its mask bit and resume the search
            // just above it. The address is never incremented past last,
            // so a full-space channel cannot wrap.
            mask_d[rd_ch_q] = 1'b0;
            ptr_d           = PTR_W'(rd_ch_q) + {{(PTR_W-1){1'b0}}, 1'b1};
            state_d         = S_SEL;
          end
        end else begin
          state_d = S_SEND;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered versions of the state being entered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and output registers; reset clears everything, mid-dump included.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ptr_q       <= '0;
      last_q      <= '0;
      rd_ch_q     <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      rd_ch_q     <= rd_ch_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_ch     = rd_ch_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  // The processor is frozen for exactly the time the dumper is busy.
  assign cpu_stall = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mips_state_dumper.sv
// -----------------------------------------------------------------------------
// tb_mips_state_dumper
//
// Directed bench for mips_state_dumper (DATA_W=16, ADDR_W=10, NUM_CH=3).
// Each dump pushes the words it should produce into a scoreboard queue; the
// output side pops and compares on every handshake. Storage contents come
// from a fixed function of (channel, address).
// -----------------------------------------------------------------------------
module tb_mips_state_dumper;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  ch_mask;
  logic [29:0] ch_last;
  logic [1:0]  rd_ch;
  logic [9:0]  rd_addr;
  logic [47:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [9:0]  out_addr;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        cpu_stall;
  logic        busy;
  logic        done;

  typedef struct {
    int          ch;
    int          addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  mips_state_dumper #(
    .DATA_W(16),
    .ADDR_W(10),
    .NUM_CH(3)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .ch_mask  (ch_mask),
    .ch_last  (ch_last),
    .rd_ch    (rd_ch),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_ch   (out_ch),
    .out_last (out_last),
    .cpu_stall(cpu_stall),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Storage content model: a fixed, distinct word per (channel, address).
  function automatic logic [15:0] mem_val(input int ch, input int a);
    return 16'(ch * 4099 + a * 37 + 165);
  endfunction

  // Combinational read port of all channels.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < 3; c++) begin
      rd_data[c*16 +: 16] = mem_val(c, int'(rd_addr));
    end
  end

  function automatic logic [29:0] pack_last(input int l0, input int l1, input int l2);
    return {10'(l2), 10'(l1), 10'(l0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_addr"},  32'(out_addr),  32'd0);
    check({tag, "_out_ch"},    32'(out_ch),    32'd0);
    check({tag, "_rd_ch"},     32'(rd_ch),     32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  // One complete dump. stall_len cycles of out_ready=0 are applied when the
  // word at stall_addr is first presented. disturb keeps start high and
  // flips ch_mask while busy. abort_addr >= 0 pulls reset_n low while that
  // word is presented and returns with reset still asserted.
  task automatic run_dump(input string tag, input logic [2:0] mask,
                          input int l0, input int l1, input int l2,
                          input int stall_addr, input int stall_len,
                          input bit disturb, input int abort_addr);
    int   lasts[3];
    int   hs_cyc;
    int   stall_rem;
    bit   got_first;
    bit   finished;
    exp_t e;

    lasts = '{l0, l1, l2};
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      if (mask[c]) begin
        for (int a = 0; a <= lasts[c]; a++) begin
          e.ch   = c;
          e.addr = a;
          e.data = mem_val(c, a);
          e.last = 1'b0;
          sb.push_back(e);
        end
      end
    end
    if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;

    @(negedge clock);
    ch_mask   = mask;
    ch_last   = pack_last(l0, l1, l2);
    start     = 1'b1;
    out_ready = 1'b1;
    hs_cyc    = 0;
    stall_rem = stall_len;
    got_first = 1'b0;
    finished  = 1'b0;

    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clock);
      if (disturb) begin
        start   = 1'b1;
        ch_mask = ~mask;
      end else begin
        start   = 1'b0;
      end

      if (out_valid && out_addr == 10'(stall_addr) && stall_rem > 0) begin
        out_ready = 1'b0;
        stall_rem--;
      end else begin
        out_ready = 1'b1;
      end

      if (cyc == 1) begin
        check({tag, "_busy_after_start"},  32'(busy),      32'd1);
        check({tag, "_valid_after_start"}, 32'(out_valid), 32'd0);
      end

      if (!got_first && out_valid) begin
        got_first = 1'b1;
        check({tag, "_first_valid_cycle"}, 32'(cyc), 32'd3);
      end

      if (sb.size() == 0) begin
        check({tag, "_no_extra_word"}, 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        check({tag, "_out_ch"},   32'(out_ch),   32'(sb[0].ch));
        check({tag, "_out_addr"}, 32'(out_addr), 32'(sb[0].addr));
        check({tag, "_out_data"}, 32'(out_data), 32'(sb[0].data));
        check({tag, "_out_last"}, 32'(out_last), 32'(sb[0].last));
        if (abort_addr >= 0 && out_addr == 10'(abort_addr)) begin
          out_ready = 1'b0;
          #2 reset_n = 1'b0;
          #1 check_all_zero({tag, "_async_reset"});
          sb.delete();
          finished = 1'b1;
        end else if (out_ready) begin
          void'(sb.pop_front());
          hs_cyc = cyc;
        end
      end else begin
        check({tag, "_last_without_valid"}, 32'(out_last), 32'd0);
      end

      if (!finished) begin
        check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd1);
        if (done) begin
          check({tag, "_done_timing"}, 32'(cyc), 32'(hs_cyc + 2));
          check({tag, "_words_left"}, 32'(sb.size()), 32'd0);
          finished = 1'b1;
          start    = 1'b0;
        end
      end
    end

    check({tag, "_completed"}, 32'(finished), 32'd1);

    if (abort_addr < 0) begin
      @(negedge clock);
      start = 1'b0;
      check({tag, "_done_one_cycle"}, 32'(done),      32'd0);
      check({tag, "_idle_busy"},      32'(busy),      32'd0);
      check({tag, "_idle_stall"},     32'(cpu_stall), 32'd0);
      check({tag, "_idle_valid"},     32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    start     = 1'b1;
    ch_mask   = 3'b111;
    ch_last   = pack_last(5, 5, 5);
    out_ready = 1'b1;

    // Reset held with active inputs: everything must stay at zero.
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    start   = 1'b0;
    ch_mask = 3'b000;
    @(negedge clock);
    check("idle_after_reset_busy", 32'(busy), 32'd0);
    check("idle_after_reset_done", 32'(done), 32'd0);

    // Single channel, 16 words, no backpressure.
    run_dump("single", 3'b001, 15, 0, 0, 0, 0, 1'b0, -1);
    // Same with out_ready low for 5 cycles on word 3.
    run_dump("backpressure", 3'b001, 15, 0, 0, 3, 5, 1'b0, -1);
    // Channel 1 skipped; start and mask disturbed while busy.
    run_dump("skip_ch1", 3'b101, 1, 4, 0, 0, 0, 1'b1, -1);
    // Empty mask: no words, done two cycles after start, start ignored.
    run_dump("empty", 3'b000, 0, 0, 0, 0, 0, 1'b1, -1);
    // All channels, including a single-word channel.
    run_dump("all_ch", 3'b111, 2, 0, 3, 1, 2, 1'b0, -1);
    // Reset while word 7 is presented.
    run_dump("abort", 3'b001, 15, 0, 0, 0, 0, 1'b0, 7);
    @(negedge clock);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    // Fresh dump after reset starts again at address 0.
    run_dump("restart", 3'b001, 3, 0, 0, 0, 0, 1'b0, -1);
    // Full address space of one channel, no wrap.
    run_dump("full_space", 3'b010, 0, 1023, 0, 0, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
